// File: rtl/adder_sched.sv
// Two-port round-robin sequencer for a shared external 16-bit adder.
// Narrow ops use one adder pass; wide ops use two, with the carry chained through a register.
module adder_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   input  logic        sub0,
   input  logic        sub1,
   input  logic        wide0,
   input  logic        wide1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] result,
   output logic        cout,
   output logic        ovf,
   output logic        zero,
   output logic        busy,
   output logic [15:0] add_x,
   output logic [15:0] add_y,
   output logic        add_cin,
   input  logic [15:0] add_sum,
   input  logic        add_cout
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LO   = 2'd1;
   localparam logic [1:0] HI   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]  state_r;
   logic [31:0] a_r;
   logic [31:0] b_r;
   logic        sub_r;
   logic        wide_r;
   logic        gnt_r;
   logic        last_r;
   logic        carry_r;
   logic        done0_r;
   logic        done1_r;
   logic [31:0] result_r;
   logic        cout_r;
   logic        ovf_r;
   logic        zero_r;
   logic        win_s;
   logic [31:0] bp_s;

   // Round-robin winner; on a tie the requester not granted last wins.
   always_comb begin
      win_s = 1'b0;
      if (req0 && req1) begin
         win_s = ~last_r;
      end else if (req1) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   assign bp_s = sub_r ? ~b_r : b_r;

   // Adder operand drive, decoded from the current state.
   always_comb begin
      add_x   = 16'h0000;
      add_y   = 16'h0000;
      add_cin = 1'b0;
      case (state_r)
         LO: begin
            add_x   = a_r[15:0];
            add_y   = bp_s[15:0];
            add_cin = sub_r;
         end
         HI: begin
            add_x   = a_r[31:16];
            add_y   = bp_s[31:16];
            add_cin = carry_r;
         end
         default: begin
            add_x   = 16'h0000;
            add_y   = 16'h0000;
            add_cin = 1'b0;
         end
      endcase
   end

   // Sequencer state, operand latches, result/flag registers and done pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         a_r      <= 32'h0000_0000;
         b_r      <= 32'h0000_0000;
         sub_r    <= 1'b0;
         wide_r   <= 1'b0;
         gnt_r    <= 1'b0;
         last_r   <= 1'b1;
         carry_r  <= 1'b0;
         done0_r  <= 1'b0;
         done1_r  <= 1'b0;
         result_r <= 32'h0000_0000;
         cout_r   <= 1'b0;
         ovf_r    <= 1'b0;
         zero_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done0_r <= 1'b0;
               done1_r <= 1'b0;
               if (req0 || req1) begin
                  a_r     <= win_s ? a1 : a0;
                  b_r     <= win_s ? b1 : b0;
                  sub_r   <= win_s ? sub1 : sub0;
                  wide_r  <= win_s ? wide1 : wide0;
                  gnt_r   <= win_s;
                  state_r <= LO;
               end
            end
            LO: begin
               result_r[15:0] <= add_sum;
               carry_r        <= add_cout;
               if (!wide_r) begin
                  result_r[31:16] <= 16'h0000;
                  cout_r  <= add_cout;
                  ovf_r   <= (a_r[15] == bp_s[15]) && (add_sum[15] != a_r[15]);
                  zero_r  <= (add_sum == 16'h0000);
                  last_r  <= gnt_r;
                  done0_r <= ~gnt_r;
                  done1_r <= gnt_r;
                  state_r <= DONE;
               end else begin
                  state_r <= HI;
               end
            end
            HI: begin
               result_r[31:16] <= add_sum;
               cout_r  <= add_cout;
               ovf_r   <= (a_r[31] == bp_s[31]) && (add_sum[15] != a_r[31]);
               zero_r  <= (add_sum == 16'h0000) && (result_r[15:0] == 16'h0000);
               last_r  <= gnt_r;
               done0_r <= ~gnt_r;
               done1_r <= gnt_r;
               state_r <= DONE;
            end
            DONE: begin
               done0_r <= 1'b0;
               done1_r <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done0_r <= 1'b0;
               done1_r <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign done0  = done0_r;
   assign done1  = done1_r;
   assign result = result_r;
   assign cout   = cout_r;
   assign ovf    = ovf_r;
   assign zero   = zero_r;
   assign busy   = (state_r != IDLE);

endmodule

// File: tb/tb_adder_sched.sv
// Scoreboard bench for adder_sched: an external 16-bit adder model, expected results
// queued at request time and compared when a done pulse appears.
module tb_adder_sched;

   logic        clk;
   logic        rst_n;
   logic        req0, req1;
   logic [31:0] a0, b0, a1, b1;
   logic        sub0, sub1, wide0, wide1;
   logic        done0, done1;
   logic [31:0] result;
   logic        cout, ovf, zero, busy;
   logic [15:0] add_x, add_y;
   logic        add_cin;
   logic [15:0] add_sum;
   logic        add_cout;
   logic [16:0] sum17_s;

   typedef struct {
      bit          idx;
      logic [31:0] res;
      bit          c;
      bit          v;
      bit          z;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_res = 32'h0;

   adder_sched dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .sub0(sub0), .sub1(sub1), .wide0(wide0), .wide1(wide1),
      .done0(done0), .done1(done1),
      .result(result), .cout(cout), .ovf(ovf), .zero(zero), .busy(busy),
      .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   assign sum17_s  = {1'b0, add_x} + {1'b0, add_y} + {16'h0000, add_cin};
   assign add_sum  = sum17_s[15:0];
   assign add_cout = sum17_s[16];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input bit idx, input logic [31:0] a, input logic [31:0] b,
                                  input bit sub, input bit wide);
      exp_t        e;
      logic [31:0] bp;
      logic [32:0] s33;
      logic [16:0] s17;
      bp = sub ? ~b : b;
      e.idx = idx;
      if (wide) begin
         s33   = {1'b0, a} + {1'b0, bp} + {32'h0, sub};
         e.res = s33[31:0];
         e.c   = s33[32];
         e.v   = (a[31] == bp[31]) && (s33[31] != a[31]);
      end else begin
         s17   = {1'b0, a[15:0]} + {1'b0, bp[15:0]} + {16'h0, sub};
         e.res = {16'h0000, s17[15:0]};
         e.c   = s17[16];
         e.v   = (a[15] == bp[15]) && (s17[15] != a[15]);
      end
      e.z = (e.res == 32'h0);
      return e;
   endfunction

   // Scoreboard: pop and compare on every done pulse.
   always @(negedge clk) begin
      if (done0 || done1) begin
         exp_t e;
         chk("done_excl", {31'h0, done0 & done1}, 32'h0);
         if (sb.size() == 0) begin
            chk("sb_unexpected_done", 32'h1, 32'h0);
         end else begin
            e = sb.pop_front();
            chk("grant_idx", {31'h0, done1}, {31'h0, e.idx});
            chk("result", result, e.res);
            chk("cout", {31'h0, cout}, {31'h0, e.c});
            chk("ovf", {31'h0, ovf}, {31'h0, e.v});
            chk("zero", {31'h0, zero}, {31'h0, e.z});
            last_res = e.res;
         end
      end
   end

   task automatic drive(input bit idx, input logic [31:0] a, input logic [31:0] b,
                        input bit sub, input bit wide);
      if (idx) begin
         req1 = 1'b1; a1 = a; b1 = b; sub1 = sub; wide1 = wide;
      end else begin
         req0 = 1'b1; a0 = a; b0 = b; sub0 = sub; wide0 = wide;
      end
      sb.push_back(model(idx, a, b, sub, wide));
   endtask

   task automatic wait_done(input bit idx, output int n);
      bit got;
      got = 1'b0;
      n   = 0;
      while (n < 12 && !got) begin
         @(negedge clk);
         n++;
         got = idx ? done1 : done0;
      end
      if (!got) chk("done_timeout", 32'h0, 32'h1);
   endtask

   task automatic run_op(input bit idx, input logic [31:0] a, input logic [31:0] b,
                         input bit sub, input bit wide);
      int n;
      drive(idx, a, b, sub, wide);
      wait_done(idx, n);
      chk(wide ? "lat_wide" : "lat_narrow", n, wide ? 32'd3 : 32'd2);
      if (idx) req1 = 1'b0; else req0 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int n;
      int cyc;
      int prev;
      bit any;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = 32'h0; b0 = 32'h0; a1 = 32'h0; b1 = 32'h0;
      sub0 = 1'b0; sub1 = 1'b0; wide0 = 1'b0; wide1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_result", result, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {30'h0, done1, done0}, 32'h0);
      chk("rst_flags", {29'h0, cout, ovf, zero}, 32'h0);
      chk("rst_adder", {add_cin, add_x, add_y[14:0]}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(1'b0, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0);
      chk("idle_adder_x", {16'h0, add_x}, 32'h0);
      chk("idle_busy", {31'h0, busy}, 32'h0);

      // Wide carry chain, probing the adder drive in LO and HI.
      drive(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
      @(negedge clk);
      chk("lo_x", {16'h0, add_x}, 32'h0000_FFFF);
      chk("lo_y", {16'h0, add_y}, 32'h0000_0001);
      chk("lo_cin", {31'h0, add_cin}, 32'h0);
      chk("lo_busy", {31'h0, busy}, 32'h1);
      @(negedge clk);
      chk("hi_cin", {31'h0, add_cin}, 32'h1);
      chk("hi_x", {16'h0, add_x}, 32'h0);
      wait_done(1'b1, n);
      chk("lat_carry", n, 32'd1);
      req1 = 1'b0;
      @(negedge clk);

      run_op(1'b0, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
      run_op(1'b1, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0);
      run_op(1'b0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
      run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
      run_op(1'b0, 32'hABCD_0005, 32'h1234_0003, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         run_op(1'(($urandom_range(0, 1))), $urandom, $urandom,
                1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
      end
      repeat (3) @(negedge clk);
      chk("result_hold", result, last_res);

      // Tie arbitration: both held high, grant order alternates 0,1,0,1.
      sb.push_back(model(1'b0, 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0));
      sb.push_back(model(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0));
      sb.push_back(model(1'b0, 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0));
      sb.push_back(model(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0));
      req0 = 1'b1; a0 = 32'h0000_0011; b0 = 32'h0000_0022; sub0 = 1'b0; wide0 = 1'b0;
      req1 = 1'b1; a1 = 32'h0000_0100; b1 = 32'h0000_0001; sub1 = 1'b1; wide1 = 1'b0;
      cyc = 0;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         any = 1'b0;
         n   = 0;
         while (n < 12 && !any) begin
            @(negedge clk);
            n++;
            cyc++;
            any = done0 | done1;
         end
         if (!any) chk("arb_timeout", 32'h0, 32'h1);
         chk("arb_order", {31'h0, done1}, (k % 2 == 1) ? 32'h1 : 32'h0);
         if (k > 0) chk("arb_gap", cyc - prev, 32'd3);
         prev = cyc;
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);

      // Reset during HI of a wide op: no done, outputs cleared at once.
      req1 = 1'b1; a1 = 32'h1234_5678; b1 = 32'h1111_1111; sub1 = 1'b0; wide1 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_busy", {31'h0, busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_result", result, 32'h0);
      chk("mid_rst_busy", {31'h0, busy}, 32'h0);
      chk("mid_rst_done", {30'h0, done1, done0}, 32'h0);
      chk("mid_rst_adder", {add_cin, add_x, add_y[14:0]}, 32'h0);
      chk("mid_rst_flags", {29'h0, cout, ovf, zero}, 32'h0);
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive(1'b1, 32'h0000_0009, 32'h0000_0001, 1'b0, 1'b0);
      sb.pop_back();
      drive(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
      wait_done(1'b0, n);
      chk("post_rst_lat", n, 32'd2);
      req0 = 1'b0; req1 = 1'b0;
      repeat (4) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_sched.md
# adder_sched

Sequencer and two-port arbiter for the shared 16-bit carry-lookahead adder in the CPU datapath. It accepts add/subtract requests from two requesters, each 16-bit (narrow) or 32-bit (wide). Round-robin arbitration picks one request at a time. The block drives the external combinational adder once for a narrow op, or twice for a wide op, chaining the carry through a register between passes. It returns a registered result with carry, overflow and zero flags, plus a one-cycle done pulse to the winning requester.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0, req1  in  1 each  request from requester 0 / 1
- a0, b0, a1, b1  in  32 each  operands; only bits [15:0] are used when narrow
- sub0, sub1  in  1 each  1 = compute a-b, 0 = compute a+b
- wide0, wide1  in  1 each  1 = 32-bit op, 0 = 16-bit op
- done0, done1  out  1 each  one-cycle completion pulse to the granted requester
- result  out  32  registered result; bits [31:16] are 0 for narrow ops
- cout  out  1  carry out of the top bit; for subtract this is not-borrow
- ovf  out  1  signed overflow of the op width
- zero  out  1  result of the op width equals 0
- busy  out  1  high in every state except IDLE
- add_x, add_y  out  16 each  operands to the external adder
- add_cin  out  1  carry-in to the external adder
- add_sum  in  16  sum from the external adder (combinational, same cycle)
- add_cout  in  1  carry out from the external adder

## Operation
- States: IDLE, LO, HI, DONE.
- **IDLE:**
  - If any req is high at the edge, grant the winner.
  - Latch the winner's a, b, sub and wide, and the granted index.
  - Go to LO.
- **Arbitration:**
  - Only one req high: that requester wins.
  - Both high: the requester not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - The pointer updates when entering DONE.
- **Adder drive (combinational from state):**
  - Let b' = sub ? ~b : b.
  - LO: add_x=a[15:0], add_y=b'[15:0], add_cin=sub.
  - HI: add_x=a[31:16], add_y=b'[31:16], add_cin=carry_reg.
  - IDLE and DONE: all adder outputs are 0.
- **LO edge:**
  - Capture add_sum into result[15:0] and add_cout into carry_reg.
  - Narrow op: compute the flags from the bit-15 terms and go to DONE.
  - Wide op: go to HI.
- **HI edge:**
  - Capture add_sum into result[31:16].
  - Compute flags from the bit-31 terms.
  - Go to DONE.
- **Flags:**
  - cout = top add_cout.
  - ovf = (a_msb == b'_msb) && (sum_msb != a_msb).
  - zero = all result bits of the op width are 0.
- **DONE:**
  - done of the granted requester is high for exactly this cycle; the other done stays 0.
  - result and flags are valid and held until the next LO edge.
  - Next state is IDLE.
- Requester obligations:
  - Hold req and operands stable until its done pulse.
  - Deassert req in the done cycle, or the request is taken as a new request.
- Deasserting req after the grant does not abort the op; it completes and done still pulses.
- req is sampled only in IDLE.
- Reset (any state, including mid-op): state=IDLE, done0=done1=0, result=0, cout=ovf=zero=0, busy=0, carry_reg=0, pointer=1, adder outputs 0. An op interrupted by reset produces no done pulse.

## Timing
- Edge E0: req sampled in IDLE.
- Narrow op: LO runs during E0–E1, and done is high during E1–E2. Done falls 2 edges after the sample edge.
- Wide op: LO during E0–E1, HI during E1–E2, done during E2–E3.
- Request-to-request throughput:
  - narrow: 3 cycles per op
  - wide: 4 cycles per op
  - The extra cycle is the IDLE cycle that follows DONE.
- busy is high from E0 through the end of the DONE cycle.
- A request arriving while busy waits. A request held through DONE is sampled at the IDLE edge after DONE.
- result, cout, ovf and zero change only on LO/HI edges and reset, never in IDLE or DONE.

## Test plan
- Narrow add: req0, a0=0x0005, b0=0x0006 -> done0 in the cycle after E1; result=0x0000000B, cout=0, ovf=0, zero=0; done1 stays 0.
- Wide add with carry chain: req1, wide1=1, a1=0x0000FFFF, b1=0x00000001 -> carry_reg=1 after LO; during HI add_cin=1; done1 after E2; result=0x00010000, cout=0.
- Subtract:
  - Wide, 0x00000000-0x00000001 -> result=0xFFFFFFFF, cout=0, ovf=0.
  - Narrow, 0x1234-0x1234 -> result=0, zero=1, cout=1.
- Overflow: narrow 0x7FFF+0x0001 -> result=0x00008000, ovf=1. Wide 0x80000000-0x00000001 -> result=0x7FFFFFFF, ovf=1.
- Arbitration: after reset, req0 and req1 held high together with narrow ops -> grant order 0,1,0,1; done pulses alternate with one IDLE cycle between ops.
- Reset mid-op: rst_n low during HI of a wide op -> no done pulse; all outputs 0 immediately; after release, a tie grants requester 0 and completes normally.
